// File: rtl/mem_pkg.sv
// Shared definitions for the burst memory controller: widths, bank field
// position and the controller state encoding.
package mem_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int LEN_W   = 4;

    // Bank select occupies the top two address bits; the rest is the byte offset.
    localparam int BANK_HI = 11;
    localparam int BANK_LO = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/mem_rd_fifo2.sv
// Two-entry read-return buffer. Push and pop may happen in the same cycle at
// any fill level; the head entry is always presented on head_data.
module mem_rd_fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;

            // Capture pushed data into this slot when the write pointer selects it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= push_data;
                end
            end
        end
    endgenerate

    // Advance pointers and occupancy on push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
    assign count     = count_reg;

    // The issue credit upstream makes a push into a full buffer impossible.
    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_reg == 2'd2)))
        else $error("mem_rd_fifo2: push into full buffer");

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst command controller in front of a banked synchronous memory port.
// Write bursts stream wr_data straight to the memory; read bursts issue
// reads under a two-beat credit and return data through a 2-entry buffer.
module mem_burst_ctrl #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int LEN_W  = mem_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mem_pkg::*;

    localparam int CNT_W = LEN_W + 1;

    state_t             state_reg,      state_next;
    logic [ADDR_W-1:0]  cur_addr_reg,   cur_addr_next;
    logic [CNT_W-1:0]   beats_left_reg, beats_left_next;
    logic               inflight_reg,   inflight_next;
    logic               last_issue_reg, last_issue_next;

    logic [1:0]         buf_count;
    logic [DATA_W:0]    buf_head;
    logic               buf_pop;
    logic [2:0]         credit_used;
    logic               issue_ok;

    // Occupancy before any same-cycle pop, so a full buffer is never pushed.
    assign credit_used = {1'b0, buf_count} + {2'b00, inflight_reg};
    assign issue_ok    = (beats_left_reg != '0) && (credit_used < 3'd2);

    assign rd_valid = (buf_count != 2'd0);
    assign buf_pop  = rd_valid && rd_ready;
    assign rd_data  = buf_head[DATA_W-1:0];
    assign rd_last  = buf_head[DATA_W];
    assign busy     = (state_reg != ST_IDLE) || rd_valid;

    // Read data returns one cycle after issue; tag it with its last-beat flag.
    mem_rd_fifo2 #(
        .WIDTH(DATA_W + 1)
    ) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_data ({last_issue_reg, mem_rdata}),
        .pop       (buf_pop),
        .head_data (buf_head),
        .count     (buf_count)
    );

    // Controller state and burst counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cur_addr_reg   <= '0;
            beats_left_reg <= '0;
            inflight_reg   <= 1'b0;
            last_issue_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cur_addr_reg   <= cur_addr_next;
            beats_left_reg <= beats_left_next;
            inflight_reg   <= inflight_next;
            last_issue_reg <= last_issue_next;
        end
    end

    // Next-state logic and memory/handshake outputs.
    always_comb begin
        state_next      = state_reg;
        cur_addr_next   = cur_addr_reg;
        beats_left_next = beats_left_reg;
        inflight_next   = 1'b0;
        last_issue_next = 1'b0;
        req_ready       = 1'b0;
        wr_ready        = 1'b0;
        mem_we          = 1'b0;
        mem_re          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;

        case (state_reg)
            ST_IDLE: begin
                req_ready = !rd_valid;
                if (req_valid && !rd_valid) begin
                    cur_addr_next   = req_addr;
                    beats_left_next = {1'b0, req_len} + CNT_W'(1);
                    state_next      = req_write ? ST_WRITE : ST_READ;
                end
            end

            ST_WRITE: begin
                wr_ready  = 1'b1;
                mem_we    = wr_valid;
                mem_addr  = cur_addr_reg;
                mem_wdata = wr_data;
                if (wr_valid) begin
                    cur_addr_next   = cur_addr_reg + ADDR_W'(1);
                    beats_left_next = beats_left_reg - CNT_W'(1);
                    if (beats_left_reg == CNT_W'(1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_READ: begin
                mem_addr = cur_addr_reg;
                if (issue_ok) begin
                    mem_re          = 1'b1;
                    inflight_next   = 1'b1;
                    last_issue_next = (beats_left_reg == CNT_W'(1));
                    cur_addr_next   = cur_addr_reg + ADDR_W'(1);
                    beats_left_next = beats_left_reg - CNT_W'(1);
                    if (beats_left_reg == CNT_W'(1)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (!inflight_reg) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a behavioural synchronous memory.
module tb_mem_burst_ctrl;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem_model [4096];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_burst_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous memory: write on mem_we, registered read data on mem_re.
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_model[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_wr_ready"},  32'(wr_ready),  32'd0);
        check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
        check({tag, "_rd_last"},   32'(rd_last),   32'd0);
        check({tag, "_rd_data"},   32'(rd_data),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_re"},    32'(mem_re),    32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    // Write burst of len+1 beats, data base + i*step, optional stall before one beat.
    task automatic write_burst(input logic [AW-1:0] addr, input int len,
                               input logic [DW-1:0] base, input logic [DW-1:0] step,
                               input int stall_beat, input int stall_cycles);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_len   = LW'(len);
        #1;
        check("wr_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i <= len; i++) begin
            a = AW'(32'(addr) + i);
            d = DW'(32'(base) + i * 32'(step));
            if (i == stall_beat) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    req_valid = 1'b0;
                    wr_valid  = 1'b0;
                    #1;
                    check("stall_no_we",  32'(mem_we),   32'd0);
                    check("stall_addr",   32'(mem_addr), 32'(a));
                    check("stall_wready", 32'(wr_ready), 32'd1);
                end
            end
            @(negedge clk);
            req_valid = 1'b0;
            wr_valid  = 1'b1;
            wr_data   = d;
            #1;
            check("wr_we",     32'(mem_we),    32'd1);
            check("wr_addr",   32'(mem_addr),  32'(a));
            check("wr_wdata",  32'(mem_wdata), 32'(d));
            check("wr_no_re",  32'(mem_re),    32'd0);
            check("wr_busy_rr",32'(req_ready), 32'd0);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("wr_done_ready", 32'(req_ready), 32'd1);
        check("wr_done_we",    32'(mem_we),    32'd0);
        check("wr_done_busy",  32'(busy),      32'd0);
        for (int i = 0; i <= len; i++) begin
            a = AW'(32'(addr) + i);
            d = DW'(32'(base) + i * 32'(step));
            check("wr_mem_content", 32'(mem_model[a]), 32'(d));
        end
        $display("write burst addr=0x%03h beats=%0d stall_cycles=%0d", addr, len + 1, stall_cycles);
    endtask

    // Read burst with a 4-cycle rd_ready pattern; abort_after>0 asserts reset
    // right after that many beats have been delivered.
    task automatic read_burst(input logic [AW-1:0] addr, input int len, input logic [3:0] pat,
                              input logic [DW-1:0] base, input logic [DW-1:0] step,
                              input int abort_after);
        int issued;
        int popped;
        logic exp_re;
        logic [DW-1:0] d;
        issued = 0;
        popped = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_len   = LW'(len);
        #1;
        check("rd_req_ready", 32'(req_ready), 32'd1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            rd_ready  = pat[cyc % 4];
            #1;
            exp_re = (issued < len + 1) && ((issued - popped) < 2);
            check("rd_mem_re", 32'(mem_re), 32'(exp_re));
            check("rd_no_we",  32'(mem_we), 32'd0);
            if (mem_re) begin
                check("rd_addr", 32'(mem_addr), 32'(AW'(32'(addr) + issued)));
                issued++;
            end
            if (rd_valid && rd_ready) begin
                d = DW'(32'(base) + popped * 32'(step));
                check("rd_data", 32'(rd_data), 32'(d));
                check("rd_last", 32'(rd_last), 32'(popped == len));
                popped++;
            end
            if (abort_after > 0 && popped == abort_after) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                $display("read burst addr=0x%03h aborted by reset after %0d beats", addr, popped);
                return;
            end
            if (popped == len + 1) break;
        end
        check("rd_beats",  32'(popped), 32'(len + 1));
        check("rd_issued", 32'(issued), 32'(len + 1));
        for (int w = 0; w < 8 && !req_ready; w++) begin
            @(negedge clk);
            #1;
            check("rd_tail_no_re", 32'(mem_re), 32'd0);
        end
        check("rd_done_ready", 32'(req_ready), 32'd1);
        check("rd_done_busy",  32'(busy),      32'd0);
        check("rd_done_valid", 32'(rd_valid),  32'd0);
        rd_ready = 1'b0;
        $display("read burst addr=0x%03h beats=%0d delivered=%0d", addr, len + 1, popped);
    endtask

    initial begin
        #2;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_busy",  32'(busy),      32'd0);

        // Single write
        write_burst(12'h005, 0, 8'hA5, 8'h00, -1, 0);
        // Write then read across a bank boundary
        write_burst(12'h3FE, 3, 8'h11, 8'h11, -1, 0);
        read_burst(12'h3FE, 3, 4'b1111, 8'h11, 8'h11, 0);
        // Address wrap at top of memory
        write_burst(12'hFFF, 1, 8'h5A, 8'h11, -1, 0);
        // Write stall mid-burst
        write_burst(12'h020, 3, 8'hC1, 8'h02, 2, 5);
        // Backpressure on a 16-beat read
        write_burst(12'h200, 15, 8'h30, 8'h05, -1, 0);
        read_burst(12'h200, 15, 4'b1001, 8'h30, 8'h05, 0);
        // Reset in the middle of a read
        write_burst(12'h600, 7, 8'h80, 8'h01, -1, 0);
        read_burst(12'h600, 7, 4'b1111, 8'h80, 8'h01, 3);
        @(negedge clk);
        check_reset_outputs("held_rst");
        rd_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        write_burst(12'h050, 0, 8'h77, 8'h00, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
